// File: rtl/jelly3_axi4l_pkg.sv
// Shared AXI4-Lite definitions: response codes and the initiator state encoding.
package jelly3_axi4l_pkg;

  localparam logic [1:0] AXI4L_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4L_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    INIT_IDLE    = 3'd0,
    INIT_WR_REQ  = 3'd1,
    INIT_WR_RESP = 3'd2,
    INIT_RD_REQ  = 3'd3,
    INIT_RD_DATA = 3'd4,
    INIT_RSP     = 3'd5
  } initiator_state_t;

endpackage

// File: rtl/jelly3_axi4l_if.sv
// AXI4-Lite bundle with master and slave views.
interface jelly3_axi4l_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = DATA_BITS / 8
) (
  input logic aresetn,
  input logic aclk
);

  logic [ADDR_BITS-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_BITS-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport m (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport s (
    input  aresetn, aclk,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/jelly3_axi4l_initiator.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out,
// with a watchdog that aborts a transaction the slave never completes.
module jelly3_axi4l_initiator
  import jelly3_axi4l_pkg::*;
#(
  parameter int ADDR_BITS    = 32,
  parameter int DATA_BITS    = 32,
  parameter int STRB_BITS    = DATA_BITS / 8,
  parameter int TIMEOUT_BITS = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                 reset,
  input  logic                 clk,

  input  logic                 s_cmd_write,
  input  logic [ADDR_BITS-1:0] s_cmd_addr,
  input  logic [DATA_BITS-1:0] s_cmd_wdata,
  input  logic [STRB_BITS-1:0] s_cmd_wstrb,
  input  logic                 s_cmd_valid,
  output logic                 s_cmd_ready,

  output logic                 m_rsp_write,
  output logic [DATA_BITS-1:0] m_rsp_rdata,
  output logic [1:0]           m_rsp_resp,
  output logic                 m_rsp_timeout,
  output logic                 m_rsp_valid,
  input  logic                 m_rsp_ready,

  output logic                 busy,

  jelly3_axi4l_if.m            m_axi4l
);

  localparam bit                      WD_ENABLE = (TIMEOUT != 0);
  localparam logic [TIMEOUT_BITS-1:0] WD_LIMIT  = TIMEOUT_BITS'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TIMEOUT_BITS-1:0] WD_MAX    = {TIMEOUT_BITS{1'b1}};

  initiator_state_t      state_q;
  logic                  write_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_BITS-1:0]  wdata_q;
  logic [STRB_BITS-1:0]  wstrb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  arvalid_q;
  logic                  rsp_write_q;
  logic [DATA_BITS-1:0]  rsp_rdata_q;
  logic [1:0]            rsp_resp_q;
  logic                  rsp_timeout_q;
  logic                  rsp_valid_q;
  logic [TIMEOUT_BITS-1:0] wd_count_q;
  logic [TIMEOUT_BITS-1:0] wd_count_d;

  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;
  logic wd_expired;
  logic in_flight;
  logic abort;

  assign aw_hs   = awvalid_q && m_axi4l.awready;
  assign w_hs    = wvalid_q  && m_axi4l.wready;
  assign aw_done = !awvalid_q || m_axi4l.awready;
  assign w_done  = !wvalid_q  || m_axi4l.wready;

  assign in_flight  = (state_q == INIT_WR_REQ) || (state_q == INIT_WR_RESP) ||
                      (state_q == INIT_RD_REQ) || (state_q == INIT_RD_DATA);
  assign wd_count_d = (wd_count_q == WD_MAX) ? wd_count_q : wd_count_q + 1'b1;
  assign wd_expired = WD_ENABLE && (wd_count_q >= WD_LIMIT);

  // Any handshake in the expiring cycle takes priority over the watchdog.
  always_comb begin
    abort = 1'b0;
    case (state_q)
      INIT_WR_REQ:  abort = wd_expired && !aw_hs && !w_hs;
      INIT_WR_RESP: abort = wd_expired && !m_axi4l.bvalid;
      INIT_RD_REQ:  abort = wd_expired && !m_axi4l.arready;
      INIT_RD_DATA: abort = wd_expired && !m_axi4l.rvalid;
      default:      abort = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= INIT_IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      wd_count_q    <= '0;
    end else begin
      if (in_flight) begin
        wd_count_q <= wd_count_d;
      end

      if (abort) begin
        awvalid_q     <= 1'b0;
        wvalid_q      <= 1'b0;
        arvalid_q     <= 1'b0;
        rsp_write_q   <= write_q;
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= AXI4L_RESP_SLVERR;
        rsp_timeout_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
        state_q       <= INIT_RSP;
      end else begin
        case (state_q)
          INIT_IDLE: begin
            if (s_cmd_valid) begin
              write_q    <= s_cmd_write;
              addr_q     <= s_cmd_addr;
              wdata_q    <= s_cmd_wdata;
              wstrb_q    <= s_cmd_wstrb;
              wd_count_q <= '0;
              if (s_cmd_write) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= INIT_WR_REQ;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= INIT_RD_REQ;
              end
            end
          end

          INIT_WR_REQ: begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (aw_done && w_done) state_q <= INIT_WR_RESP;
          end

          INIT_WR_RESP: begin
            if (m_axi4l.bvalid) begin
              rsp_write_q   <= 1'b1;
              rsp_rdata_q   <= '0;
              rsp_resp_q    <= m_axi4l.bresp;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state_q       <= INIT_RSP;
            end
          end

          INIT_RD_REQ: begin
            if (m_axi4l.arready) begin
              arvalid_q <= 1'b0;
              state_q   <= INIT_RD_DATA;
            end
          end

          INIT_RD_DATA: begin
            if (m_axi4l.rvalid) begin
              rsp_write_q   <= 1'b0;
              rsp_rdata_q   <= m_axi4l.rdata;
              rsp_resp_q    <= m_axi4l.rresp;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state_q       <= INIT_RSP;
            end
          end

          INIT_RSP: begin
            if (m_rsp_ready) begin
              rsp_valid_q <= 1'b0;
              state_q     <= INIT_IDLE;
            end
          end

          default: begin
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            state_q     <= INIT_IDLE;
          end
        endcase
      end
    end
  end

  assign s_cmd_ready   = (state_q == INIT_IDLE);
  assign busy          = (state_q != INIT_IDLE);

  assign m_rsp_write   = rsp_write_q;
  assign m_rsp_rdata   = rsp_rdata_q;
  assign m_rsp_resp    = rsp_resp_q;
  assign m_rsp_timeout = rsp_timeout_q;
  assign m_rsp_valid   = rsp_valid_q;

  assign m_axi4l.awaddr  = addr_q;
  assign m_axi4l.awprot  = 3'b000;
  assign m_axi4l.awvalid = awvalid_q;
  assign m_axi4l.wdata   = wdata_q;
  assign m_axi4l.wstrb   = wstrb_q;
  assign m_axi4l.wvalid  = wvalid_q;
  assign m_axi4l.bready  = (state_q == INIT_WR_RESP);
  assign m_axi4l.araddr  = addr_q;
  assign m_axi4l.arprot  = 3'b000;
  assign m_axi4l.arvalid = arvalid_q;
  assign m_axi4l.rready  = (state_q == INIT_RD_DATA);

endmodule

// File: tb/tb_jelly3_axi4l_initiator.sv
// Scoreboard bench for jelly3_axi4l_initiator against a small register slave with stall knobs.
module tb_jelly3_axi4l_initiator;

  logic        clk;
  logic        reset;
  logic        s_cmd_write;
  logic [31:0] s_cmd_addr;
  logic [31:0] s_cmd_wdata;
  logic [3:0]  s_cmd_wstrb;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic        m_rsp_write;
  logic [31:0] m_rsp_rdata;
  logic [1:0]  m_rsp_resp;
  logic        m_rsp_timeout;
  logic        m_rsp_valid;
  logic        m_rsp_ready;
  logic        busy;

  jelly3_axi4l_if #(.ADDR_BITS(32), .DATA_BITS(32)) axi (.aresetn(~reset), .aclk(clk));

  jelly3_axi4l_initiator #(
    .ADDR_BITS(32), .DATA_BITS(32), .STRB_BITS(4), .TIMEOUT_BITS(16), .TIMEOUT(16)
  ) dut (
    .reset(reset), .clk(clk),
    .s_cmd_write(s_cmd_write), .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata),
    .s_cmd_wstrb(s_cmd_wstrb), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .m_rsp_write(m_rsp_write), .m_rsp_rdata(m_rsp_rdata), .m_rsp_resp(m_rsp_resp),
    .m_rsp_timeout(m_rsp_timeout), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .busy(busy), .m_axi4l(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register slave ----------------
  int          aw_delay_cfg = 0;
  logic        never_ar = 1'b0;
  logic        b_stall = 1'b0;
  int          aw_wait;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, wd_l;
  logic [3:0]  ws_l;
  logic [31:0] mem [64];
  logic        aw_hs, w_hs;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  assign axi.awready = (aw_wait >= aw_delay_cfg);
  assign axi.wready  = 1'b1;
  assign axi.arready = !never_ar;
  assign aw_hs   = axi.awvalid && axi.awready;
  assign w_hs    = axi.wvalid && axi.wready;
  assign wr_addr = aw_hs ? axi.awaddr : aw_addr_l;
  assign wr_data = w_hs ? axi.wdata : wd_l;
  assign wr_strb = w_hs ? axi.wstrb : ws_l;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= 32'h0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0;
      aw_addr_l <= 32'h0; wd_l <= 32'h0; ws_l <= 4'h0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1; aw_addr_l <= axi.awaddr; aw_wait <= 0;
      end else if (axi.awvalid) begin
        aw_wait <= aw_wait + 1;
      end
      if (w_hs) begin
        w_got <= 1'b1; wd_l <= axi.wdata; ws_l <= axi.wstrb;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs) && !axi.bvalid && !b_stall) begin
        mem[wr_addr[7:2]] <= merge(mem[wr_addr[7:2]], wr_data, wr_strb);
        axi.bvalid <= 1'b1; axi.bresp <= 2'b00;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1; axi.rresp <= 2'b00;
        axi.rdata  <= (axi.araddr == 32'h0) ? 32'h0000_527a : mem[axi.araddr[7:2]];
      end
    end
  end

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  int   acc_cyc = 0;
  int   rel;
  int   aw_rel = -1, w_rel = -1, b_cnt = 0, ar_hi = 0;
  logic wv_at2 = 1'b0;
  logic rsp_seen = 1'b0;

  // Monitor: per-transaction timing capture plus response scoreboard.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (s_cmd_valid && s_cmd_ready) begin
        acc_cyc = cyc; aw_rel = -1; w_rel = -1; b_cnt = 0; ar_hi = 0; wv_at2 = 1'b1;
      end
      rel = cyc - acc_cyc;
      if (aw_hs) aw_rel = rel;
      if (w_hs)  w_rel  = rel;
      if (rel == 2) wv_at2 = axi.wvalid;
      if (axi.arvalid) ar_hi++;
      if (axi.bvalid && axi.bready) b_cnt++;
      if (m_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          check_eq("rsp_write",   64'(m_rsp_write),   64'(exp_q[0].wr));
          check_eq("rsp_rdata",   64'(m_rsp_rdata),   64'(exp_q[0].rdata));
          check_eq("rsp_resp",    64'(m_rsp_resp),    64'(exp_q[0].resp));
          check_eq("rsp_timeout", 64'(m_rsp_timeout), 64'(exp_q[0].to));
          if (!rsp_seen && exp_q[0].lat > 0)
            check_eq("rsp_latency", 64'(rel), 64'(exp_q[0].lat));
          rsp_seen = 1'b1;
          if (m_rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input exp_t e);
    int n;
    @(posedge clk); #1;
    s_cmd_write = wr; s_cmd_addr = addr; s_cmd_wdata = data; s_cmd_wstrb = strb;
    s_cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_cmd_ready && n < 200) begin
      @(negedge clk); n++;
    end
    if (s_cmd_ready) exp_q.push_back(e);
    else check_eq("cmd_accept_wait", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    check_eq("rsp_wait_expired", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic wr, input logic [31:0] rd, input logic [1:0] resp,
                              input logic to, input int lat);
    exp_t e;
    e.wr = wr; e.rdata = rd; e.resp = resp; e.to = to; e.lat = lat;
    return e;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    reset = 1'b1; m_rsp_ready = 1'b1;
    s_cmd_valid = 1'b0; s_cmd_write = 1'b0; s_cmd_addr = 32'h0;
    s_cmd_wdata = 32'h0; s_cmd_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", 64'(s_cmd_ready), 64'd1);
    check_eq("rst_busy",      64'(busy),        64'd0);
    check_eq("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    check_eq("rst_awvalid",   64'(axi.awvalid), 64'd0);
    check_eq("rst_arvalid",   64'(axi.arvalid), 64'd0);
    check_eq("rst_rsp_rdata", 64'(m_rsp_rdata), 64'd0);
    check_eq("rst_rsp_resp",  64'(m_rsp_resp),  64'd0);

    // Basic write, then readback; CORE_ID read.
    do_cmd(1'b1, 32'h88, 32'h3a6, 4'hF, mk(1'b1, 32'h0, 2'b00, 1'b0, 3));
    wait_done();
    check_eq("wr_aw_cycle", 64'(aw_rel), 64'd1);
    check_eq("wr_w_cycle",  64'(w_rel),  64'd1);
    do_cmd(1'b0, 32'h88, 32'h0, 4'h0, mk(1'b0, 32'h3a6, 2'b00, 1'b0, 3));
    wait_done();
    do_cmd(1'b0, 32'h00, 32'hdead_beef, 4'hF, mk(1'b0, 32'h0000_527a, 2'b00, 1'b0, 3));
    wait_done();

    // Skewed AW/W handshake with partial strobes.
    aw_delay_cfg = 3;
    do_cmd(1'b1, 32'h10, 32'h1234_5678, 4'b0101, mk(1'b1, 32'h0, 2'b00, 1'b0, 6));
    wait_done();
    aw_delay_cfg = 0;
    check_eq("skew_w_cycle",  64'(w_rel),  64'd1);
    check_eq("skew_aw_cycle", 64'(aw_rel), 64'd4);
    check_eq("skew_wvalid_c2", 64'(wv_at2), 64'd0);
    check_eq("skew_b_count",  64'(b_cnt),  64'd1);
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, mk(1'b0, 32'h0034_0078, 2'b00, 1'b0, 3));
    wait_done();

    // Response backpressure.
    m_rsp_ready = 1'b0;
    do_cmd(1'b0, 32'h88, 32'h0, 4'h0, mk(1'b0, 32'h3a6, 2'b00, 1'b0, 3));
    n = 0;
    while (!m_rsp_valid && n < 50) begin
      @(negedge clk); n++;
    end
    check_eq("bp_rsp_valid", 64'(m_rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_cmd_ready_held", 64'(s_cmd_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 m_rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_cmd_ready_hs_cycle", 64'(s_cmd_ready), 64'd0);
    @(negedge clk);
    check_eq("bp_cmd_ready_after", 64'(s_cmd_ready), 64'd1);
    check_eq("bp_rsp_valid_after", 64'(m_rsp_valid), 64'd0);
    wait_done();

    // Reset while waiting in WR_RESP.
    b_stall = 1'b1;
    do_cmd(1'b1, 32'h30, 32'haa, 4'hF, mk(1'b1, 32'h0, 2'b00, 1'b0, 0));
    n = 0;
    while (!axi.bready && n < 50) begin
      @(negedge clk); n++;
    end
    check_eq("rm_in_wr_resp", 64'(axi.bready), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    exp_q.delete();
    check_eq("rm_awvalid",   64'(axi.awvalid), 64'd0);
    check_eq("rm_wvalid",    64'(axi.wvalid),  64'd0);
    check_eq("rm_bready",    64'(axi.bready),  64'd0);
    check_eq("rm_arvalid",   64'(axi.arvalid), 64'd0);
    check_eq("rm_rready",    64'(axi.rready),  64'd0);
    check_eq("rm_busy",      64'(busy),        64'd0);
    check_eq("rm_rsp_valid", 64'(m_rsp_valid), 64'd0);
    check_eq("rm_rsp_rdata", 64'(m_rsp_rdata), 64'd0);
    b_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rm_cmd_ready", 64'(s_cmd_ready), 64'd1);
    do_cmd(1'b1, 32'h30, 32'h55, 4'hF, mk(1'b1, 32'h0, 2'b00, 1'b0, 3));
    wait_done();
    do_cmd(1'b0, 32'h30, 32'h0, 4'h0, mk(1'b0, 32'h55, 2'b00, 1'b0, 3));
    wait_done();

    // Watchdog: slave never accepts the read address.
    never_ar = 1'b1;
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0, mk(1'b0, 32'h0, 2'b10, 1'b1, 17));
    wait_done();
    never_ar = 1'b0;
    check_eq("to_arvalid_cycles", 64'(ar_hi), 64'd16);
    check_eq("to_arvalid_low", 64'(axi.arvalid), 64'd0);
    do_cmd(1'b0, 32'h00, 32'h0, 4'h0, mk(1'b0, 32'h0000_527a, 2'b00, 1'b0, 3));
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
